// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide, big-endian data memory with combinational read
// and single-cycle write. Adds byte/halfword loads with extension and read-modify-write sub-word stores.
module load_store_unit #(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int MEM_BYTES      = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
    input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
    output logic                      resp_valid,
    output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
    output logic                      resp_err,
    output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
    output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
    output logic                      mem_write_en,
    input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);
    localparam logic [ADDR_BUS_WIDTH-1:0] LAST_ADDR = ADDR_BUS_WIDTH'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t                    state_reg;
    logic                      write_reg;
    logic                      unsigned_reg;
    logic [1:0]                size_reg;
    logic [15:0]               wdata_reg;
    logic                      req_ready_reg;
    logic                      resp_valid_reg;
    logic                      resp_err_reg;
    logic [DATA_BUS_WIDTH-1:0] resp_rdata_reg;
    logic [ADDR_BUS_WIDTH-1:0] mem_addr_reg;
    logic [DATA_BUS_WIDTH-1:0] mem_write_data_reg;
    logic                      mem_write_en_reg;

    logic [DATA_BUS_WIDTH-1:0] load_data;
    logic [DATA_BUS_WIDTH-1:0] merge_data;
    logic                      fill_bit;
    logic                      req_bad;

    // The addressed byte is always the top byte of the read word, so the
    // extension bit is rd[MSB] for both byte and halfword fields.
    always_comb begin
        fill_bit   = ~unsigned_reg & mem_read_data[DATA_BUS_WIDTH-1];
        load_data  = mem_read_data;
        merge_data = mem_read_data;
        case (size_reg)
            2'd0: begin
                load_data  = {{(DATA_BUS_WIDTH-8){fill_bit}}, mem_read_data[DATA_BUS_WIDTH-1 -: 8]};
                merge_data = {wdata_reg[7:0], mem_read_data[DATA_BUS_WIDTH-9:0]};
            end
            2'd1: begin
                load_data  = {{(DATA_BUS_WIDTH-16){fill_bit}}, mem_read_data[DATA_BUS_WIDTH-1 -: 16]};
                merge_data = {wdata_reg, mem_read_data[DATA_BUS_WIDTH-17:0]};
            end
            default: ;
        endcase
    end

    assign req_bad = (req_size == 2'd3) || (req_addr > LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            write_reg          <= 1'b0;
            unsigned_reg       <= 1'b0;
            size_reg           <= 2'd0;
            wdata_reg          <= '0;
            req_ready_reg      <= 1'b1;
            resp_valid_reg     <= 1'b0;
            resp_err_reg       <= 1'b0;
            resp_rdata_reg     <= '0;
            mem_addr_reg       <= '0;
            mem_write_data_reg <= '0;
            mem_write_en_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg     <= req_write;
                        size_reg      <= req_size;
                        unsigned_reg  <= req_unsigned;
                        wdata_reg     <= req_wdata[15:0];
                        req_ready_reg <= 1'b0;
                        if (req_bad) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= '0;
                        end else begin
                            state_reg    <= ACCESS;
                            mem_addr_reg <= req_addr;
                            if (req_write && req_size == 2'd2) begin
                                mem_write_en_reg   <= 1'b1;
                                mem_write_data_reg <= req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (write_reg && size_reg != 2'd2) begin
                        // Sub-word store: keep the address, drive the merged word next cycle.
                        state_reg          <= WRITE;
                        mem_write_en_reg   <= 1'b1;
                        mem_write_data_reg <= merge_data;
                    end else begin
                        state_reg          <= RESP;
                        resp_valid_reg     <= 1'b1;
                        resp_err_reg       <= 1'b0;
                        resp_rdata_reg     <= write_reg ? '0 : load_data;
                        mem_addr_reg       <= '0;
                        mem_write_en_reg   <= 1'b0;
                        mem_write_data_reg <= '0;
                    end
                end
                WRITE: begin
                    state_reg          <= RESP;
                    resp_valid_reg     <= 1'b1;
                    resp_err_reg       <= 1'b0;
                    resp_rdata_reg     <= '0;
                    mem_addr_reg       <= '0;
                    mem_write_en_reg   <= 1'b0;
                    mem_write_data_reg <= '0;
                end
                default: begin
                    state_reg      <= IDLE;
                    req_ready_reg  <= 1'b1;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_err       = resp_err_reg;
    assign resp_rdata     = resp_rdata_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_write_data = mem_write_data_reg;
    // Reset must suppress a write already in flight, since the memory commits on this same edge.
    assign mem_write_en   = mem_write_en_reg & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-level reference memory model feeds a
// scoreboard queue that a response monitor drains and compares.
module tb_load_store_unit;
    localparam int MB = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .MEM_BYTES(MB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_data(mem_read_data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          writes;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] dmem    [0:MB-1];
    logic [7:0] ref_mem [0:MB-1];
    int cyc = 0, write_count = 0, exp_writes = 0;
    int compared = 0, mismatched = 0, issued = 0, resp_count = 0, last_accept = 0;

    // Attached memory: combinational read, write commits on the strobe edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_en) begin
            write_count <= write_count + 1;
            if (mem_addr <= 32'(MB - 4))
                for (int i = 0; i < 4; i++)
                    dmem[int'(mem_addr) + i] <= mem_write_data[31-8*i -: 8];
        end
    end

    always_comb begin
        mem_read_data = '0;
        if (mem_addr <= 32'(MB - 4))
            for (int i = 0; i < 4; i++)
                mem_read_data[31-8*i -: 8] = dmem[int'(mem_addr) + i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: works on individual bytes with plain arithmetic.
    task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int n;
        longint unsigned v;
        e.rdata = '0;
        e.lat = 0;
        e.acc = 0;
        e.err = (sz == 2'd3) || (a > 32'(MB - 4));
        if (!e.err) begin
            n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            if (w) begin
                for (int i = 0; i < n; i++)
                    ref_mem[int'(a) + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
                exp_writes++;
                e.lat = (n == 4) ? 1 : 2;
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v * 256 + 64'(ref_mem[int'(a) + i]);
                if (!uns && v >= (64'd1 << (8 * n - 1)))
                    v = v + (64'd1 << 32) - (64'd1 << (8 * n));
                e.rdata = v[31:0];
                e.lat = 1;
            end
        end
        e.writes = exp_writes;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got ready=%b after %0d cycles, required 1", req_ready, waited);
            req_valid = 1'b0;
            return;
        end
        model(w, sz, uns, a, wd, e);
        e.acc = cyc + 1;
        last_accept = cyc + 1;
        exp_q.push_back(e);
        issued++;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%08h, required no response", resp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                resp_count++;
                $display("resp %0d: rdata=0x%08h err=%b latency=%0d writes=%0d",
                         resp_count, resp_rdata, resp_err, cyc - e.acc, write_count);
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
                check("write_count", 32'(write_count), 32'(e.writes));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int prev;
        int waited;
        logic [1:0] sz;
        int r;
        for (int i = 0; i < MB; i++) begin
            dmem[i] = 8'($urandom);
            ref_mem[i] = dmem[i];
        end

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_resp_err", 32'(resp_err), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_write_data", mem_write_data, 32'd0);
        check("reset_mem_write_en", 32'(mem_write_en), 32'd0);
        reset = 1'b0;

        // Directed sequence
        issue(1'b1, 2'd2, 1'b0, 32'd8, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'd8, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'd8, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'd9, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'd10, 32'h0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'd9, 32'hAAAAAA12, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'd61, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h00000100, 32'h12345678, 1'b0);
        issue(1'b1, 2'd3, 1'b0, 32'd0, 32'h12345678, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'd4, 32'h11223344, 1'b0);
        drain();

        // Byte store aborted by reset while in WRITE
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd4; req_wdata = 32'h00000055; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("abort_accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("abort_write_en_gated", 32'(mem_write_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("abort_write_count", 32'(write_count), 32'(exp_writes));
        issue(1'b0, 2'd2, 1'b0, 32'd4, 32'h0, 1'b0);
        drain();

        // Back-to-back loads with req_valid held high
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            issue(1'b0, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, MB - 4)), 32'h0, 1'b1);
            if (k > 0) check("accept_spacing", 32'(last_accept - prev), 32'd3);
            prev = last_accept;
        end
        req_valid = 1'b0;
        drain();

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 15);
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MB - 1)),
                  $urandom, 1'b0);
        end
        drain();

        check("total_writes", 32'(write_count), 32'(exp_writes));
        check("resp_per_accept", 32'(resp_count), 32'(issued));
        bad = 0;
        for (int i = 0; i < MB; i++)
            if (dmem[i] !== ref_mem[i]) bad++;
        check("mem_image_bad_bytes", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the byte-addressed, big-endian data memory. It accepts one load or store request at a time from the execute stage and issues the word-wide accesses the memory supports: combinational read, single-cycle synchronous write of 4 bytes at addr..addr+3. It adds byte and halfword access with sign or zero extension, implements sub-word stores as read-modify-write, and flags out-of-range or illegal requests.

## Interface
Parameters:
- ADDR_BUS_WIDTH, 32, address width on both sides.
- DATA_BUS_WIDTH, 32, data width; only 32 is supported.
- MEM_BYTES, 64, byte depth of the attached data memory, used for the range check.

Ports:
- clk  in  1  rising-edge clock. This is the block's only clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend loads when high; otherwise sign-extend.
- req_addr  in  ADDR_BUS_WIDTH  byte address.
- req_wdata  in  DATA_BUS_WIDTH  store data; sub-word stores use the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_BUS_WIDTH  load result, valid with resp_valid.
- resp_err  out  1  request rejected, valid with resp_valid.
- mem_addr  out  ADDR_BUS_WIDTH  address to the data memory.
- mem_write_data  out  DATA_BUS_WIDTH  write word to the data memory.
- mem_write_en  out  1  write strobe to the data memory.
- mem_read_data  in  DATA_BUS_WIDTH  combinational read word from the data memory.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, size, unsigned, addr and wdata.
  - If size==3 or addr > MEM_BYTES-4, set the error flag and go to RESP. No memory access occurs.
  - Otherwise go to ACCESS.
- ACCESS: mem_addr = latched addr.
  - Load: capture the extracted result and go to RESP.
  - Word store: mem_write_en = 1, mem_write_data = wdata, then go to RESP.
  - Sub-word store: capture mem_read_data without writing, then go to WRITE.
- WRITE: mem_addr = latched addr, mem_write_en = 1, merged word driven, then go to RESP.
- RESP: resp_valid = 1 with resp_rdata and resp_err, then go to IDLE.
- Byte order is big-endian: the byte at addr sits in bits [31:24] of the read word.
- Load extraction:
  - Byte load uses rd[31:24].
  - Halfword load uses rd[31:16].
  - Word load uses rd as-is.
  - Extension fills upper bits with the top bit of the extracted field, or with zeros when unsigned.
- Store merge:
  - Byte store: {wdata[7:0], rd[23:0]}.
  - Halfword store: {wdata[15:0], rd[15:0]}.
- Alignment is not required. Any addr in 0..MEM_BYTES-4 is legal for every size.
- The range check uses the full ADDR_BUS_WIDTH-bit unsigned address. The same bound applies to byte and halfword accesses, because the memory always touches 4 bytes.
- On error: resp_rdata = 0, resp_err = 1, and mem_write_en is never asserted.
- Outside ACCESS and WRITE: mem_addr = 0, mem_write_data = 0, mem_write_en = 0.
- For loads, resp_rdata holds its value until the next RESP. For stores, resp_rdata is 0.

## Timing
- Reset values after the reset edge:
  - state = IDLE, req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_addr = 0, mem_write_data = 0, mem_write_en = 0.
- Reset during ACCESS or WRITE: return to IDLE at that edge. There is no memory write in any later cycle and no resp_valid for the aborted request.
- Request accepted at edge T (req_valid && req_ready).
- Latency to resp_valid:
  - Load and word store: ACCESS in cycle T..T+1, resp_valid in cycle T+1..T+2.
  - Sub-word store: ACCESS, then WRITE, then RESP; resp_valid one cycle later than a load.
  - Error: resp_valid in the cycle immediately after accept.
- The memory write commits on the clk edge that ends the mem_write_en cycle. A load issued next sees the new data.
- Throughput:
  - Next accept is possible in the IDLE cycle after RESP.
  - Minimum spacing is 3 cycles for loads and word stores, 4 for sub-word stores.
- req_valid outside IDLE is ignored. The requester must hold the request until accepted.

## Test plan
- Reset, then word store of 0xDEADBEEF to addr 8, then word load from 8 → resp_rdata = 0xDEADBEEF, resp_err = 0, mem_write_en high for exactly one cycle.
- Memory at 8 holds 0xDEADBEEF:
  - Signed byte load at 8 → 0xFFFFFFDE.
  - Unsigned byte load at 8 → 0x000000DE.
  - Signed halfword load at 9 → 0xFFFFADBE.
  - Unsigned halfword load at 10 → 0x0000BEEF.
- Byte store of 0x12 to addr 9 over 0xDEADBEEF at 8, then word load at 8 → 0xDE12BEEF. Check that the store's resp_valid is one cycle later than a load's.
- Error cases, each giving resp_err = 1, resp_rdata = 0, no write, and resp_valid 1 cycle after accept:
  - Load at addr 61.
  - Store at addr 0x00000100.
  - A request with size = 3.
- Reset asserted during WRITE of a byte store to addr 4 (memory holds 0x11223344) → no resp_valid, memory unchanged, req_ready = 1 next cycle.
- req_valid held high across back-to-back loads → accepts exactly every 3 cycles, one resp_valid per accept.
